// File: rtl/calc_pkg.sv
// Shared constants, FSM state type and helpers for the result-merge path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

    localparam int CALC_W = 8;
    localparam int CALC_N = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // True when more than one bit of the (zero-extended) valid mask is set.
    function automatic logic multi_hot(input logic [15:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cnt += 32'(v[i]);
        end
        return (cnt > 1);
    endfunction

endpackage

// File: rtl/masked_or_reduce.sv
// Masks each channel with its valid bit and ORs all channels together; flags multi-valid.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module masked_or_reduce
    import calc_pkg::*;
#(
    parameter int N = CALC_N,
    parameter int W = CALC_W
) (
    input  logic [N*W-1:0] i_data,
    input  logic [N-1:0]   i_valid,
    output logic [W-1:0]   o_merged,
    output logic           o_collision
);

    // Invalid channels contribute nothing, whatever their data lines carry.
    always_comb begin
        o_merged = '0;
        for (int k = 0; k < N; k++) begin
            o_merged = o_merged | (i_data[k*W +: W] & {W{i_valid[k]}});
        end
    end

    assign o_collision = multi_hot(16'(i_valid));

endmodule

// File: rtl/result_combiner.sv
// Merges N valid/data result channels by OR into a one-entry valid/ready output register; counts collisions.
// Latency: 1 cycle from accept to out_valid. Optional out_parity port under RESULT_PARITY_EN.
// Backpressure: in_ready = EMPTY | out_ready; full throughput via same-edge drain and replace.
module result_combiner
    import calc_pkg::*;
#(
    parameter int N     = CALC_N,
    parameter int W     = CALC_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic             out_collision,
`ifdef RESULT_PARITY_EN
    output logic             out_parity,
`endif
    input  logic             out_ready,
    output logic [CNT_W-1:0] err_count
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_data;
    logic             r_collision;
    logic [CNT_W-1:0] r_err;
    logic [W-1:0]     w_merged;
    logic             w_collision;
    logic             w_accept;

    masked_or_reduce #(
        .N (N),
        .W (W)
    ) u_reduce (
        .i_data      (in_data),
        .i_valid     (in_valid),
        .o_merged    (w_merged),
        .o_collision (w_collision)
    );

    // Ready never looks at in_valid, so upstream can use it without a comb loop.
    assign in_ready = (r_state == EMPTY) | out_ready;
    assign w_accept = (|in_valid) & in_ready;

    // State register; clr behaves as a synchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else if (clr) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and output valid: accept wins over drain so a same-edge replace stays FULL.
    always_comb begin
        w_state_nxt = r_state;
        out_valid   = (r_state == FULL);
        if (w_accept) begin
            w_state_nxt = FULL;
        end else if ((r_state == FULL) && out_ready) begin
            w_state_nxt = EMPTY;
        end
    end

    // Result register loads only on accept; it simply holds while draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_collision <= 1'b0;
        end else if (clr) begin
            r_data      <= '0;
            r_collision <= 1'b0;
        end else if (w_accept) begin
            r_data      <= w_merged;
            r_collision <= w_collision;
        end
    end

    // Saturating collision counter, cleared only by reset or clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= '0;
        end else if (clr) begin
            r_err <= '0;
        end else if (w_accept && w_collision && (r_err != {CNT_W{1'b1}})) begin
            r_err <= r_err + 1'b1;
        end
    end

    assign out_data      = r_data;
    assign out_collision = r_collision;
    assign err_count     = r_err;

`ifdef RESULT_PARITY_EN
    logic r_parity;

    // Parity bit travels with the data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (clr) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^w_merged;
        end
    end

    assign out_parity = r_parity;
`endif

endmodule

// File: tb/tb_result_combiner.sv
// Scoreboard bench for result_combiner with N=4, W=8, CNT_W=8.
// Latency: expects results one cycle after accept.
// Backpressure: drives out_ready patterns, including sustained stalls.
module tb_result_combiner;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_collision;
    logic        out_ready;
    logic [7:0]  err_count;
`ifdef RESULT_PARITY_EN
    logic        out_parity;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int m_err    = 0;
    logic [8:0] sb[$];   // {collision, data}

    result_combiner #(
        .N     (4),
        .W     (8),
        .CNT_W (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (clr),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_collision (out_collision),
`ifdef RESULT_PARITY_EN
        .out_parity    (out_parity),
`endif
        .out_ready     (out_ready),
        .err_count     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_or(input logic [3:0] v, input logic [31:0] d);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 4; k++) begin
            if (v[k]) r = r | d[k*8 +: 8];
        end
        return r;
    endfunction

    // One clock cycle: drive, check outputs mid-cycle, predict the edge, advance.
    task automatic cyc(input logic [3:0] v, input logic [31:0] d, input logic ordy, input logic c);
        logic exp_rdy;
        logic acc;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clr       = c;
        #3;
        exp_rdy = (sb.size() == 0) || ordy;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(sb[0][7:0]));
            chk("out_collision", 32'(out_collision), 32'(sb[0][8]));
`ifdef RESULT_PARITY_EN
            chk("out_parity", 32'(out_parity), 32'(^sb[0][7:0]));
`endif
        end
        chk("err_count", 32'(err_count), 32'(m_err));
        acc = (v != 4'b0000) && exp_rdy;
        if (c) begin
            sb.delete();
            m_err = 0;
        end else begin
            if ((sb.size() != 0) && ordy) void'(sb.pop_front());
            if (acc) begin
                sb.push_back({($countones(v) > 1), exp_or(v, d)});
                if (($countones(v) > 1) && (m_err < 255)) m_err++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 4'b0000;
        in_data   = 32'h0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All-zero valid never produces a result.
        cyc(4'b0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        cyc(4'b0000, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Single channel, other channels masked.
        cyc(4'b0100, 32'hFF3C_FFFF, 1'b1, 1'b0);
        // Collision 0x01 | 0x80.
        cyc(4'b0011, 32'hFFFF_8001, 1'b1, 1'b0);
        cyc(4'b0000, 32'h0, 1'b0, 1'b0);
        chk("coll_err_count", 32'(err_count), 32'd1);

        // Asynchronous reset mid-cycle while FULL.
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_err_count", 32'(err_count), 32'd0);
        chk("arst_out_collision", 32'(out_collision), 32'd0);
        sb.delete();
        m_err    = 0;
        in_valid = 4'b0000;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Synchronous clear, with a competing accept that must lose.
        cyc(4'b0011, 32'h0000_0F70, 1'b1, 1'b0);
        cyc(4'b0000, 32'h0, 1'b0, 1'b0);
        cyc(4'b0011, 32'h0000_0F70, 1'b0, 1'b1);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_out_data", 32'(out_data), 32'd0);
        chk("clr_err_count", 32'(err_count), 32'd0);

        // Backpressure: hold 0x3C while ch3=0x55 is offered, then same-edge replace.
        cyc(4'b0100, 32'h0A3C_0000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(4'b1000, 32'h5511_2233, 1'b0, 1'b0);
        cyc(4'b1000, 32'h5511_2233, 1'b1, 1'b0);
        cyc(4'b0000, 32'h0, 1'b0, 1'b0);
        chk("bp_replace_data", 32'(out_data), 32'h55);

        // Back-to-back throughput then drain.
        cyc(4'b0000, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] v;
            v = 4'b0001 << i;
            cyc(v, $urandom, 1'b1, 1'b0);
        end
        cyc(4'b0000, 32'h0, 1'b1, 1'b0);
        cyc(4'b0000, 32'h0, 1'b1, 1'b0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Saturation of the collision counter.
        for (int i = 0; i < 300; i++) cyc(4'b0110, $urandom, 1'b1, 1'b0);
        cyc(4'b0000, 32'h0, 1'b1, 1'b0);
        chk("sat_err_count", 32'(err_count), 32'd255);

`ifdef RESULT_PARITY_EN
        cyc(4'b0001, 32'h0000_0007, 1'b1, 1'b0);
        chk("parity_07", 32'(out_parity), 32'd1);
        cyc(4'b0000, 32'h0, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
